// File: rtl/psum_accum_pkg.sv
// Shared widths and FSM encoding for the PE group, psum_accum and the ofmap writer.
package psum_accum_pkg;
  localparam int PSUM_W  = 18;
  localparam int ACC_W   = 28;
  localparam int OFMAP_W = 8;
  localparam int BIAS_W  = 16;
  localparam int LEN_W   = 10;
  localparam int OUTS_W  = 16;
  localparam int SHIFT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_POST  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;
endpackage

// File: rtl/psum_post.sv
// Per-lane requantisation: round-half-up arithmetic shift, optional ReLU, int8 clamp.
module psum_post
  import psum_accum_pkg::*;
#(
  parameter int AW = ACC_W
) (
  input  logic signed [AW-1:0]      acc,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic                      relu,
  output logic [OFMAP_W-1:0]        value,
  output logic                      clamp
);
  localparam logic signed [AW:0] MAX_V = (AW+1)'(127);
  localparam logic signed [AW:0] MIN_V = (AW+1)'(-128);

  logic signed [AW:0] rnd;
  logic signed [AW:0] sum;
  logic signed [AW:0] r;

  always_comb begin
    rnd = '0;
    if (shift != '0) rnd = (AW+1)'(1) << (shift - SHIFT_W'(1));
    // One guard bit so the rounding add cannot wrap.
    sum = {acc[AW-1], acc} + rnd;
    r = sum >>> shift;
    if (relu && r[AW]) r = '0;
    clamp = 1'b0;
    value = r[OFMAP_W-1:0];
    if (r > MAX_V) begin
      value = {1'b0, {(OFMAP_W-1){1'b1}}};
      clamp = 1'b1;
    end else if (r < MIN_V) begin
      value = {1'b1, {(OFMAP_W-1){1'b0}}};
      clamp = 1'b1;
    end
  end
endmodule

// File: rtl/psum_accum.sv
// Accumulates len psum pairs per pixel onto bias, requantises to int8 and hands
// two ofmap values out over valid/ready; psum_ready stalls the PE array otherwise.
module psum_accum #(
  parameter int PSUM_W = psum_accum_pkg::PSUM_W,
  parameter int ACC_W  = psum_accum_pkg::ACC_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_load,
  input  logic [psum_accum_pkg::LEN_W-1:0]   cfg_len,
  input  logic [psum_accum_pkg::OUTS_W-1:0]  cfg_outs,
  input  logic [psum_accum_pkg::SHIFT_W-1:0] cfg_shift,
  input  logic                               cfg_relu,
  input  logic [psum_accum_pkg::BIAS_W-1:0]  bias1_in,
  input  logic [psum_accum_pkg::BIAS_W-1:0]  bias2_in,
  input  logic                               psum_valid,
  output logic                               psum_ready,
  input  logic [PSUM_W-1:0]                  psum1_in,
  input  logic [PSUM_W-1:0]                  psum2_in,
  output logic                               ofmap_valid,
  input  logic                               ofmap_ready,
  output logic [psum_accum_pkg::OFMAP_W-1:0] ofmap1_out,
  output logic [psum_accum_pkg::OFMAP_W-1:0] ofmap2_out,
  output logic                               busy,
  output logic                               done,
  output logic                               sat_flag
);
  import psum_accum_pkg::*;

  state_t state, state_n;
  logic [LEN_W-1:0]   len_m1, beat_cnt;
  logic [OUTS_W-1:0]  outs_m1, pix_cnt;
  logic [SHIFT_W-1:0] shift_q;
  logic               relu_q;
  logic [BIAS_W-1:0]  bias1_q, bias2_q;
  logic signed [ACC_W-1:0] acc1, acc2;
  logic signed [ACC_W-1:0] bias1_ext, bias2_ext, psum1_ext, psum2_ext;
  logic [OFMAP_W-1:0] post1, post2;
  logic               clamp1, clamp2;
  logic               beat, out_hs, last_beat, last_pix;

  assign bias1_ext = {{(ACC_W-BIAS_W){bias1_q[BIAS_W-1]}}, bias1_q};
  assign bias2_ext = {{(ACC_W-BIAS_W){bias2_q[BIAS_W-1]}}, bias2_q};
  assign psum1_ext = {{(ACC_W-PSUM_W){psum1_in[PSUM_W-1]}}, psum1_in};
  assign psum2_ext = {{(ACC_W-PSUM_W){psum2_in[PSUM_W-1]}}, psum2_in};

  assign beat      = (state == ST_ACCUM) && psum_valid;
  assign out_hs    = (state == ST_OUT) && ofmap_ready;
  assign last_beat = (beat_cnt == len_m1);
  assign last_pix  = (pix_cnt == outs_m1);

  psum_post #(.AW(ACC_W)) u_post1 (.acc(acc1), .shift(shift_q), .relu(relu_q), .value(post1), .clamp(clamp1));
  psum_post #(.AW(ACC_W)) u_post2 (.acc(acc2), .shift(shift_q), .relu(relu_q), .value(post2), .clamp(clamp2));

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (cfg_load) state_n = ST_ACCUM;
      ST_ACCUM: if (beat && last_beat) state_n = ST_POST;
      ST_POST:  state_n = ST_OUT;
      ST_OUT:   if (ofmap_ready) state_n = last_pix ? ST_IDLE : ST_ACCUM;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_m1      <= '0;
      outs_m1     <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      bias1_q     <= '0;
      bias2_q     <= '0;
      acc1        <= '0;
      acc2        <= '0;
      beat_cnt    <= '0;
      pix_cnt     <= '0;
      ofmap1_out  <= '0;
      ofmap2_out  <= '0;
      ofmap_valid <= 1'b0;
      psum_ready  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sat_flag    <= 1'b0;
    end else begin
      state      <= state_n;
      psum_ready <= (state_n == ST_ACCUM);
      busy       <= (state_n != ST_IDLE);
      done       <= 1'b0;
      case (state)
        ST_IDLE: if (cfg_load) begin
          len_m1   <= (cfg_len == '0) ? '0 : cfg_len - LEN_W'(1);
          outs_m1  <= (cfg_outs == '0) ? '0 : cfg_outs - OUTS_W'(1);
          shift_q  <= cfg_shift;
          relu_q   <= cfg_relu;
          bias1_q  <= bias1_in;
          bias2_q  <= bias2_in;
          acc1     <= {{(ACC_W-BIAS_W){bias1_in[BIAS_W-1]}}, bias1_in};
          acc2     <= {{(ACC_W-BIAS_W){bias2_in[BIAS_W-1]}}, bias2_in};
          beat_cnt <= '0;
          pix_cnt  <= '0;
          sat_flag <= 1'b0;
        end
        ST_ACCUM: if (beat) begin
          acc1     <= acc1 + psum1_ext;
          acc2     <= acc2 + psum2_ext;
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
        ST_POST: begin
          ofmap1_out  <= post1;
          ofmap2_out  <= post2;
          ofmap_valid <= 1'b1;
          sat_flag    <= sat_flag | clamp1 | clamp2;
        end
        ST_OUT: if (out_hs) begin
          ofmap_valid <= 1'b0;
          if (last_pix) begin
            done <= 1'b1;
          end else begin
            pix_cnt  <= pix_cnt + OUTS_W'(1);
            acc1     <= bias1_ext;
            acc2     <= bias2_ext;
            beat_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
